operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter N, default 16, data word width.
REQ-002 Parameter M, default 4, register address width.
REQ-003 Parameter O, default 16, number of registers (2^M).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 inValid  input  1  upstream instruction valid.
REQ-007 inReady  output  1  block accepts instruction this cycle.
REQ-008 inOp  input  4  opcode, passed through unmodified.
REQ-009 inSrc0, inSrc1  input  M  source register addresses.
REQ-010 inDest  input  M  destination register address.
REQ-011 inDestWrite  input  1  instruction will write inDest.
REQ-012 readAddr0, readAddr1  output  M  register file read addresses.
REQ-013 rfData0, rfData1  input  N  register file combinational read data.
REQ-014 wbEnable  input  1  writeback this cycle (same strobe drives register file write).
REQ-015 wbAddr  input  M  writeback address.
REQ-016 wbData  input  N  writeback data.
REQ-017 outValid  output  1  operand bundle valid to execute stage.
REQ-018 outReady  input  1  execute stage accepts bundle.
REQ-019 outOp  output  4; outOperand0, outOperand1  output  N; outDest  output  M; outDestWrite  output  1  registered bundle.
REQ-020 busyMask  output  O  bit i set = register i has pending write.

Function
REQ-021 readAddr0/readAddr1 SHALL equal inSrc0/inSrc1 combinationally.
REQ-022 Bypass: operand k SHALL be wbData when wbEnable=1 and wbAddr==inSrck, else rfDatak (register file write lands at the next edge, so same-cycle bypass is mandatory).
REQ-023 Hazard: hazk = busyMask[inSrck] and not (wbEnable and wbAddr==inSrck); stall = haz0 or haz1.
REQ-024 inReady SHALL be (not outValid or outReady) and not stall; combinational.
REQ-025 Accept = inValid and inReady; on accept the output register SHALL load inOp, bypassed operands, inDest, inDestWrite, and outValid SHALL become 1 next cycle.
REQ-026 Without accept, outValid SHALL clear when outReady=1 and hold otherwise; bundle fields SHALL hold while outValid=1 and outReady=0.
REQ-027 Latency: accepted instruction SHALL appear on outputs exactly 1 cycle later; back-to-back accept at 1 per cycle SHALL be supported when outReady=1 and no hazard.
REQ-028 Scoreboard: wbEnable SHALL clear busyMask[wbAddr]; accept with inDestWrite=1 SHALL set busyMask[inDest].
REQ-029 Same-cycle set and clear of the same bit: set SHALL win.
REQ-030 Source equal to dest of the accepting instruction (e.g. r3=r3+r1) SHALL read pre-issue state; no self-stall.
REQ-031 wbEnable on a non-busy register SHALL be legal; bit stays 0 (unless set per REQ-029).
REQ-032 Stall SHALL NOT depend on inValid for its value, but no state changes without accept.
REQ-033 Block SHALL NOT modify operand data other than selection per REQ-022.

Reset
REQ-034 rst=1 at a posedge SHALL set outValid=0, busyMask=0, outOp/outOperand0/outOperand1/outDest/outDestWrite=0, overriding any simultaneous accept or writeback.
REQ-035 Reset mid-stall SHALL drop the held bundle and all pending busy bits; first cycle after rst deasserts, inReady=1.

Verification
REQ-036 Reset, then issue op=2 src0=1 src1=2 dest=3 write=1 with rfData0=0x0011 rfData1=0x0022, outReady=1 -> next cycle outValid=1, operands 0x0011/0x0022, outDest=3, busyMask=0x0008.
REQ-037 With busyMask[3]=1, issue src0=3 without writeback -> inReady=0 for each cycle; assert wbEnable wbAddr=3 wbData=0xBEEF -> accepted that cycle, outOperand0=0xBEEF next cycle, busyMask[3]=0.
REQ-038 outReady=0 with outValid=1 -> inReady=0, bundle stable 5 cycles; outReady=1 -> pending input accepted same cycle, new bundle next cycle.
REQ-039 busyMask[5]=1, wbEnable wbAddr=5 and accept dest=5 write=1 same cycle -> busyMask[5]=1 after edge.
REQ-040 Stalled instruction plus held bundle, assert rst one cycle -> outValid=0, busyMask=0x0000, inReady=1 next cycle.
REQ-041 Stream 8 independent instructions with outReady=1 -> 8 consecutive outValid cycles, order and operands preserved.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Instruction-in / operand-bundle-out handshake bundle for operand_fetch.
// master = upstream issuer and downstream consumer; slave = operand_fetch.
interface operand_fetch_if #(
   parameter int N = 16,
   parameter int M = 4
);
   logic         inValid;
   logic         inReady;
   logic [3:0]   inOp;
   logic [M-1:0] inSrc0;
   logic [M-1:0] inSrc1;
   logic [M-1:0] inDest;
   logic         inDestWrite;

   logic         outValid;
   logic         outReady;
   logic [3:0]   outOp;
   logic [N-1:0] outOperand0;
   logic [N-1:0] outOperand1;
   logic [M-1:0] outDest;
   logic         outDestWrite;

   modport master (
      output inValid, inOp, inSrc0, inSrc1, inDest, inDestWrite, outReady,
      input  inReady, outValid, outOp, outOperand0, outOperand1, outDest, outDestWrite
   );

   modport slave (
      input  inValid, inOp, inSrc0, inSrc1, inDest, inDestWrite, outReady,
      output inReady, outValid, outOp, outOperand0, outOperand1, outDest, outDestWrite
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read with writeback bypass, busy-bit scoreboard
// for read-after-write hazards, and a single registered output bundle.
module operand_fetch #(
   parameter int N = 16,
   parameter int M = 4,
   parameter int O = 16
) (
   input  logic          clk,
   input  logic          rst,
   operand_fetch_if.slave bus,
   output logic [M-1:0]  readAddr0,
   output logic [M-1:0]  readAddr1,
   input  logic [N-1:0]  rfData0,
   input  logic [N-1:0]  rfData1,
   input  logic          wbEnable,
   input  logic [M-1:0]  wbAddr,
   input  logic [N-1:0]  wbData,
   output logic [O-1:0]  busyMask
);

   logic         fwd0, fwd1;
   logic         haz0, haz1;
   logic         stall;
   logic         inReadyInt;
   logic         accept;
   logic [N-1:0] operand0, operand1;
   logic [O-1:0] setMask, clrMask, busyNext;

   logic         outValidQ;
   logic [3:0]   outOpQ;
   logic [N-1:0] outOperand0Q, outOperand1Q;
   logic [M-1:0] outDestQ;
   logic         outDestWriteQ;

   assign readAddr0 = bus.inSrc0;
   assign readAddr1 = bus.inSrc1;

   // The register file only commits a writeback at the next edge, so a
   // same-cycle writeback must be forwarded and also resolves the hazard.
   assign fwd0     = wbEnable && (wbAddr == bus.inSrc0);
   assign fwd1     = wbEnable && (wbAddr == bus.inSrc1);
   assign operand0 = fwd0 ? wbData : rfData0;
   assign operand1 = fwd1 ? wbData : rfData1;

   assign haz0  = busyMask[bus.inSrc0] && !fwd0;
   assign haz1  = busyMask[bus.inSrc1] && !fwd1;
   assign stall = haz0 || haz1;

   assign inReadyInt = (!outValidQ || bus.outReady) && !stall;
   assign accept     = bus.inValid && inReadyInt;

   always_comb begin
      clrMask = '0;
      setMask = '0;
      if (wbEnable) begin
         clrMask = {{(O-1){1'b0}}, 1'b1} << wbAddr;
      end
      if (accept && bus.inDestWrite) begin
         setMask = {{(O-1){1'b0}}, 1'b1} << bus.inDest;
      end
      // Applying the set after the clear lets a new issue win over a retiring write.
      busyNext = (busyMask & ~clrMask) | setMask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busyMask      <= '0;
         outValidQ     <= 1'b0;
         outOpQ        <= '0;
         outOperand0Q  <= '0;
         outOperand1Q  <= '0;
         outDestQ      <= '0;
         outDestWriteQ <= 1'b0;
      end else begin
         busyMask <= busyNext;
         if (accept) begin
            outValidQ     <= 1'b1;
            outOpQ        <= bus.inOp;
            outOperand0Q  <= operand0;
            outOperand1Q  <= operand1;
            outDestQ      <= bus.inDest;
            outDestWriteQ <= bus.inDestWrite;
         end else if (bus.outReady) begin
            outValidQ <= 1'b0;
         end
      end
   end

   assign bus.inReady      = inReadyInt;
   assign bus.outValid     = outValidQ;
   assign bus.outOp        = outOpQ;
   assign bus.outOperand0  = outOperand0Q;
   assign bus.outOperand1  = outOperand1Q;
   assign bus.outDest      = outDestQ;
   assign bus.outDestWrite = outDestWriteQ;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a behavioural register file / busy-set
// model predicts readiness and queues expected bundles; a monitor pops on handshake.
module tb_operand_fetch;
   localparam int N = 16;
   localparam int M = 4;
   localparam int O = 16;

   typedef struct packed {
      logic [3:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [M-1:0] d;
      logic         w;
   } bundle_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_fetch_if #(.N(N), .M(M)) bus ();

   logic [M-1:0] readAddr0, readAddr1, wbAddr;
   logic [N-1:0] rfData0, rfData1, wbData;
   logic         wbEnable;
   logic [O-1:0] busyMask;

   operand_fetch #(.N(N), .M(M), .O(O)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .readAddr0(readAddr0), .readAddr1(readAddr1),
      .rfData0(rfData0), .rfData1(rfData1),
      .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
      .busyMask(busyMask)
   );

   logic [N-1:0] rf [O];
   bit           mBusy [O];
   bit           mOutValid;
   bundle_t      q [$];
   int           compared   = 0;
   int           mismatched = 0;

   assign rfData0 = rf[readAddr0];
   assign rfData1 = rf[readAddr1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [O-1:0] busyVec();
      logic [O-1:0] v;
      for (int i = 0; i < O; i++) v[i] = mBusy[i];
      return v;
   endfunction

   // Monitor: a bundle is consumed when valid and ready meet at the coming edge.
   always @(negedge clk) begin
      bundle_t got, exp;
      if (!rst && bus.outValid && bus.outReady) begin
         got = {bus.outOp, bus.outOperand0, bus.outOperand1, bus.outDest, bus.outDestWrite};
         if (q.size() == 0) begin
            chk("unexpectedBundle", 64'(got), 64'hDEAD_0000_0000);
         end else begin
            exp = q.pop_front();
            chk("bundle", 64'(got), 64'(exp));
         end
      end
   end

   // One clock cycle: drive, predict readiness, queue expected bundle, advance model.
   task automatic cycle(input bit r, input bit iv, input logic [3:0] op,
                        input logic [M-1:0] s0, input logic [M-1:0] s1,
                        input logic [M-1:0] d, input bit dw,
                        input bit we, input logic [M-1:0] wa, input logic [N-1:0] wd,
                        input bit ordy);
      bit           hz0, hz1, expReady, acc;
      logic [N-1:0] a, b;
      rst = r;
      bus.inValid = iv; bus.inOp = op; bus.inSrc0 = s0; bus.inSrc1 = s1;
      bus.inDest = d; bus.inDestWrite = dw; bus.outReady = ordy;
      wbEnable = we; wbAddr = wa; wbData = wd;
      #1;
      hz0 = mBusy[s0] && !(we && wa == s0);
      hz1 = mBusy[s1] && !(we && wa == s1);
      expReady = (!mOutValid || ordy) && !hz0 && !hz1;
      acc = !r && iv && expReady;
      if (!r) begin
         chk("inReady", 64'(bus.inReady), 64'(expReady));
         chk("readAddr", 64'({readAddr0, readAddr1}), 64'({s0, s1}));
      end
      if (acc) begin
         a = (we && wa == s0) ? wd : rf[s0];
         b = (we && wa == s1) ? wd : rf[s1];
         q.push_back('{op: op, a: a, b: b, d: d, w: dw});
      end
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < O; i++) mBusy[i] = 1'b0;
         mOutValid = 1'b0;
         q.delete();
      end else begin
         if (we) mBusy[wa] = 1'b0;
         if (acc && dw) mBusy[d] = 1'b1;
         if (acc) mOutValid = 1'b1;
         else if (ordy) mOutValid = 1'b0;
      end
      if (we) rf[wa] = wd;
      chk("busyMask", 64'(busyMask), 64'(busyVec()));
      chk("outValid", 64'(bus.outValid), 64'(mOutValid));
      if (r) chk("resetBundle", 64'({bus.outOp, bus.outOperand0, bus.outOperand1,
                                       bus.outDest, bus.outDestWrite}), 64'h0);
   endtask

   initial begin
      logic [M-1:0] s0, s1, d, wa;
      logic [N-1:0] heldA, heldB;
      int           busyList [$];
      int           drain;

      for (int i = 0; i < O; i++) begin
         rf[i] = N'($urandom);
         mBusy[i] = 1'b0;
      end
      rf[1] = 16'h0011;
      rf[2] = 16'h0022;
      mOutValid = 1'b0;
      bus.inValid = 0; bus.inOp = 0; bus.inSrc0 = 0; bus.inSrc1 = 0;
      bus.inDest = 0; bus.inDestWrite = 0; bus.outReady = 0;
      wbEnable = 0; wbAddr = 0; wbData = 0;
      @(posedge clk);
      #1;

      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Basic issue with scoreboard set
      cycle(0, 1, 4'd2, 4'd1, 4'd2, 4'd3, 1, 0, 0, 0, 1);
      chk("issueOperand0", 64'(bus.outOperand0), 64'h0011);
      chk("issueOperand1", 64'(bus.outOperand1), 64'h0022);
      chk("issueDest", 64'(bus.outDest), 64'd3);
      chk("issueBusy", 64'(busyMask), 64'h0008);

      // RAW stall on r3, released by same-cycle writeback bypass
      repeat (3) cycle(0, 1, 4'd5, 4'd3, 4'd0, 4'd4, 0, 0, 0, 0, 1);
      cycle(0, 1, 4'd5, 4'd3, 4'd0, 4'd4, 0, 1, 4'd3, 16'hBEEF, 1);
      chk("bypassOperand0", 64'(bus.outOperand0), 64'hBEEF);
      chk("bypassBusy3", 64'(busyMask[3]), 64'd0);

      // Backpressure: bundle held stable for 5 cycles
      cycle(0, 1, 4'd7, 4'd6, 4'd7, 4'd8, 0, 0, 0, 0, 1);
      heldA = rf[6];
      heldB = rf[7];
      repeat (5) begin
         cycle(0, 1, 4'd9, 4'd9, 4'd10, 4'd11, 0, 0, 0, 0, 0);
         chk("heldBundle", 64'({bus.outOp, bus.outOperand0, bus.outOperand1, bus.outDest, bus.outDestWrite}),
             64'({4'd7, heldA, heldB, 4'd8, 1'b0}));
      end
      cycle(0, 1, 4'd9, 4'd9, 4'd10, 4'd11, 0, 0, 0, 0, 1);
      chk("releasedOperand0", 64'(bus.outOperand0), 64'(rf[9]));

      // Set beats clear on the same busy bit
      cycle(0, 1, 4'd1, 4'd0, 4'd1, 4'd5, 1, 0, 0, 0, 1);
      cycle(0, 1, 4'd2, 4'd2, 4'd4, 4'd5, 1, 1, 4'd5, 16'h1234, 1);
      chk("setWinsBusy5", 64'(busyMask[5]), 64'd1);

      // Reset while stalled with a held bundle
      cycle(0, 1, 4'd3, 4'd5, 4'd0, 4'd6, 0, 0, 0, 0, 0);
      cycle(0, 1, 4'd3, 4'd5, 4'd0, 4'd6, 0, 0, 0, 0, 0);
      cycle(1, 1, 4'd3, 4'd5, 4'd0, 4'd6, 0, 0, 0, 0, 0);
      chk("rstOutValid", 64'(bus.outValid), 64'd0);
      chk("rstBusy", 64'(busyMask), 64'h0);
      cycle(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1);

      // Stream of 8 independent instructions
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 4'(i), 4'(i), 4'(7 - i), 4'(8 + i), 1, 0, 0, 0, 1);
         chk("streamValid", 64'(bus.outValid), 64'd1);
      end

      // Randomized traffic
      repeat (400) begin
         s0 = M'($urandom); s1 = M'($urandom); d = M'($urandom);
         busyList.delete();
         for (int i = 0; i < O; i++) if (mBusy[i]) busyList.push_back(i);
         if (busyList.size() != 0 && $urandom_range(0, 3) != 0)
            wa = M'(busyList[$urandom_range(0, busyList.size() - 1)]);
         else
            wa = M'($urandom);
         cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), 4'($urandom),
               s0, s1, d, 1'($urandom), 1'($urandom), wa, N'($urandom),
               ($urandom_range(0, 3) != 0));
      end

      drain = 0;
      while (q.size() != 0 && drain < 20) begin
         cycle(0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1);
         drain++;
      end
      chk("drainEmpty", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
